lcd_nibble_writer: RTL and testbench

//  Downstream consumer of the LCD opcode issued by the ROM-driven sequencer.

---
 rtl/lcd_nibble_writer.sv | 155 +++++++++++++++
 tb/tb_lcd_nibble_writer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_nibble_writer.sv
// ---------------------------------------------------------------------------
// lcd_nibble_writer
//
// Writes one 4-bit nibble (plus register select) to the Spartan-3E character
// LCD per request, producing setup / enable-pulse / hold / recovery timing
// from a single 8-bit down-counter. The two nibbles of a byte are two
// separate requests.
//
// Handshake: write is a request strobe that is only looked at while the
// block is idle (busy=0). A request seen at a clock edge in IDLE is accepted
// at that edge and busy rises with it; requests while busy=1 are dropped,
// not queued. done pulses for one cycle when the nibble has completed its
// recovery time, and a new request may be accepted in that same cycle.
//
// Ports
//   clk        in   system clock (50 MHz)
//   rst_n      in   asynchronous active-low reset; aborts any transfer
//   write      in   request strobe
//   data[3:0]  in   nibble for LCD DB[7:4]
//   rs         in   0 = command register, 1 = data register
//   busy       out  high while a nibble is in flight
//   done       out  one-cycle pulse at completion
//   lcd_e      out  LCD enable
//   lcd_rs     out  LCD register select
//   lcd_rw     out  LCD read/write, always 0 (write only)
//   lcd_d[3:0] out  LCD DB[7:4] (SF_D[11:8])
//   sf_ce0     out  StrataFlash chip enable, held 1 to release the shared bus
//   state_dbg  out  current FSM state encoding
//
// Each timing parameter must lie in 1..255 (8-bit counter holds N-1).
// ---------------------------------------------------------------------------
module lcd_nibble_writer #(
    parameter int unsigned SETUP_CYCLES  = 2,
    parameter int unsigned E_HIGH_CYCLES = 12,
    parameter int unsigned HOLD_CYCLES   = 1,
    parameter int unsigned GAP_CYCLES    = 50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       write,
    input  logic [3:0] data,
    input  logic       rs,
    output logic       busy,
    output logic       done,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [3:0] lcd_d,
    output logic       sf_ce0,
    output logic [2:0] state_dbg
);

    // Counter reload values: a state lasting N cycles starts at N-1 and
    // advances on the edge where the count reaches zero.
    localparam logic [7:0] SETUP_LOAD = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] EHIGH_LOAD = 8'(E_HIGH_CYCLES - 1);
    localparam logic [7:0] HOLD_LOAD  = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] GAP_LOAD   = 8'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        EHIGH = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       done_d;
    logic       accept;

    assign accept    = (state_q == IDLE) && write;
    assign lcd_rw    = 1'b0;
    assign sf_ce0    = 1'b1;
    assign state_dbg = state_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (write) begin
                    state_d = SETUP;
                    cnt_d   = SETUP_LOAD;
                end
            end
            SETUP: begin
                if (cnt_q == 8'd0) begin
                    state_d = EHIGH;
                    cnt_d   = EHIGH_LOAD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            EHIGH: begin
                if (cnt_q == 8'd0) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LOAD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            HOLD: begin
                if (cnt_q == 8'd0) begin
                    state_d = GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            GAP: begin
                if (cnt_q == 8'd0) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // busy and lcd_e are decoded from the next state so they are clean flop
    // outputs that change on the same edge as the state itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            lcd_e   <= 1'b0;
            lcd_rs  <= 1'b0;
            lcd_d   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy    <= (state_d != IDLE);
            done    <= done_d;
            lcd_e   <= (state_d == EHIGH);
            // Bus lines only change on accept, so they stay valid through
            // setup, the enable pulse, hold and the idle time that follows.
            if (accept) begin
                lcd_d  <= data;
                lcd_rs <= rs;
            end
        end
    end

endmodule

// File: tb/tb_lcd_nibble_writer.sv
module tb_lcd_nibble_writer;

  localparam int S0 = 2, E0 = 12, H0 = 1, G0 = 50;
  localparam int T0 = S0 + E0 + H0 + G0;   // 65
  localparam int T1 = 4;                   // all parameters = 1

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DUT0: default timing
  logic       write0 = 1'b0, rs0 = 1'b0;
  logic [3:0] data0 = 4'd0;
  logic       busy0, done0, e0, rso0, rw0, ce0_0;
  logic [3:0] d0;
  logic [2:0] st0;

  // DUT1: all timing parameters = 1
  logic       write1 = 1'b0, rs1 = 1'b0;
  logic [3:0] data1 = 4'd0;
  logic       busy1, done1, e1, rso1, rw1, ce0_1;
  logic [3:0] d1;
  logic [2:0] st1;

  lcd_nibble_writer dut0 (
    .clk(clk), .rst_n(rst_n), .write(write0), .data(data0), .rs(rs0),
    .busy(busy0), .done(done0), .lcd_e(e0), .lcd_rs(rso0), .lcd_rw(rw0),
    .lcd_d(d0), .sf_ce0(ce0_0), .state_dbg(st0)
  );

  lcd_nibble_writer #(
    .SETUP_CYCLES(1), .E_HIGH_CYCLES(1), .HOLD_CYCLES(1), .GAP_CYCLES(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .write(write1), .data(data1), .rs(rs1),
    .busy(busy1), .done(done1), .lcd_e(e1), .lcd_rs(rso1), .lcd_rw(rw1),
    .lcd_d(d1), .sf_ce0(ce0_1), .state_dbg(st1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // ---------------- scoreboard: {rs, d} expected at each enable rise -------
  logic [4:0] exp_q0[$];
  logic [4:0] exp_q1[$];
  logic       pe0 = 1'b0, pe1 = 1'b0;
  int         cyc = 0;
  logic       held_mode = 1'b0;
  int         held_rises = 0, held_last = 0, held_dones = 0;
  logic [4:0] sb_exp0, sb_exp1;

  always @(negedge clk) begin
    cyc++;
    if (rst_n && e0 && !pe0) begin
      if (exp_q0.size() == 0) begin
        check("sb0_unexpected_pulse", 1, 0);
      end else begin
        sb_exp0 = exp_q0.pop_front();
        check("sb0_rs_d", int'({rso0, d0}), int'(sb_exp0));
      end
      if (held_mode) begin
        if (held_rises > 0) check("held_period", cyc - held_last, T0 + 1);
        held_rises++;
        held_last = cyc;
      end
    end
    if (held_mode && done0) held_dones++;
    pe0 = e0;
  end

  always @(negedge clk) begin
    if (rst_n && e1 && !pe1) begin
      if (exp_q1.size() == 0) begin
        check("sb1_unexpected_pulse", 1, 0);
      end else begin
        sb_exp1 = exp_q1.pop_front();
        check("sb1_rs_d", int'({rso1, d1}), int'(sb_exp1));
      end
    end
    pe1 = e1;
  end

  // ---------------- driver ------------------------------------------------
  task automatic drive(input int sel, input logic w, input logic [3:0] d, input logic r);
    if (sel == 0) begin
      write0 = w; data0 = d; rs0 = r;
    end else begin
      write1 = w; data1 = d; rs1 = r;
    end
  endtask

  // One request, then observe one full transfer. k counts negedge samples
  // after the accept edge. poke > 0 drives an extra (to be ignored) request
  // of 8 at sample poke.
  task automatic xfer(input int sel, input logic [3:0] d, input logic r, input int poke,
                      input int exp_rise, input int exp_ehigh, input int exp_busy,
                      input int exp_done_k);
    int first_rise, e_cnt, busy_cnt, done_cnt, done_k, bad_hold;
    logic se, sb, sd, srs;
    logic [3:0] sdat;
    first_rise = 0; e_cnt = 0; busy_cnt = 0; done_cnt = 0; done_k = 0; bad_hold = 0;
    @(negedge clk);
    drive(sel, 1'b1, d, r);
    if (sel == 0) exp_q0.push_back({r, d}); else exp_q1.push_back({r, d});
    for (int k = 1; k <= exp_done_k + 2; k++) begin
      @(negedge clk);
      if (sel == 0) begin
        se = e0; sb = busy0; sd = done0; srs = rso0; sdat = d0;
      end else begin
        se = e1; sb = busy1; sd = done1; srs = rso1; sdat = d1;
      end
      if (se && first_rise == 0) first_rise = k;
      if (se) e_cnt++;
      if (sb) busy_cnt++;
      if (sd) begin done_cnt++; done_k = k; end
      if (k <= exp_done_k && {srs, sdat} != {r, d}) bad_hold++;
      if (k == 1) drive(sel, 1'b0, 4'd0, 1'b0);
      if (poke > 0 && k == poke) drive(sel, 1'b1, 4'h8, ~r);
      if (poke > 0 && k == poke + 1) drive(sel, 1'b0, 4'd0, 1'b0);
    end
    check("e_rise_latency", first_rise, exp_rise);
    check("e_high_cycles", e_cnt, exp_ehigh);
    check("busy_cycles", busy_cnt, exp_busy);
    check("done_count", done_cnt, 1);
    check("done_latency", done_k, exp_done_k);
    check("rs_d_stable", bad_hold, 0);
  endtask

  // ---------------- vector table -------------------------------------------
  typedef struct {
    int         sel;
    logic [3:0] data;
    logic       rs;
    int         poke;
    int         exp_rise;
    int         exp_ehigh;
    int         exp_busy;
    int         exp_done_k;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{0, 4'h3, 1'b0, 0,  S0 + 1, E0, T0, T0 + 1};
    vecs[1] = '{0, 4'h4, 1'b1, 0,  S0 + 1, E0, T0, T0 + 1};
    vecs[2] = '{0, 4'h3, 1'b0, 10, S0 + 1, E0, T0, T0 + 1};
    vecs[3] = '{0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 0, S0 + 1, E0, T0, T0 + 1};
    vecs[4] = '{0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 0, S0 + 1, E0, T0, T0 + 1};
    vecs[5] = '{1, 4'h6, 1'b1, 0, 2, 1, T1, T1 + 1};
    vecs[6] = '{1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 0, 2, 1, T1, T1 + 1};

    // reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_e", e0, 0);
    check("rst_rs", rso0, 0);
    check("rst_d", d0, 0);
    check("rst_rw", rw0, 0);
    check("rst_ce0", ce0_0, 1);
    check("rst_state", st0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", busy0, 0);
    check("idle_busy1", busy1, 0);

    for (int i = 0; i < 7; i++)
      xfer(vecs[i].sel, vecs[i].data, vecs[i].rs, vecs[i].poke, vecs[i].exp_rise,
           vecs[i].exp_ehigh, vecs[i].exp_busy, vecs[i].exp_done_k);

    // write held high 200 cycles: accepts at 0, 66, 132, 198
    @(negedge clk);
    held_mode = 1'b1; held_rises = 0; held_dones = 0;
    drive(0, 1'b1, 4'h5, 1'b1);
    for (int n = 0; n < 4; n++) exp_q0.push_back({1'b1, 4'h5});
    for (int k = 1; k <= 270; k++) begin
      @(negedge clk);
      if (k == 200) drive(0, 1'b0, 4'd0, 1'b0);
    end
    held_mode = 1'b0;
    check("held_rises", held_rises, 4);
    check("held_dones", held_dones, 4);
    check("held_final_busy", busy0, 0);

    // reset during the enable pulse
    @(negedge clk);
    drive(0, 1'b1, 4'h9, 1'b0);
    exp_q0.push_back({1'b0, 4'h9});
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) drive(0, 1'b0, 4'd0, 1'b0);
    end
    check("abort_e_before", e0, 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_e_async", e0, 0);
    check("abort_busy_async", busy0, 0);
    check("abort_state", st0, 0);
    begin
      int dn;
      dn = 0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (done0) dn++;
      end
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (done0) dn++;
      end
      check("abort_no_done", dn, 0);
    end
    xfer(0, 4'h3, 1'b0, 0, S0 + 1, E0, T0, T0 + 1);

    check("sb0_drained", exp_q0.size(), 0);
    check("sb1_drained", exp_q1.size(), 0);
    check("rw_const", rw0 | rw1, 0);
    check("ce0_const", ce0_0 & ce0_1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
